// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank.
// Build option: DEBOUNCE_REPEAT_EN adds per-channel auto-repeat strobes.
package debounce_pkg;

   localparam int DEB_STABLE_CYCLES = 100000;
   localparam int DEB_REPEAT_DELAY  = 50000000;
   localparam int DEB_REPEAT_PERIOD = 10000000;

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } deb_state_e;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability FSM, edge pulses.
// Build option: DEBOUNCE_REPEAT_EN adds the auto-repeat counter.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
   parameter int CNT_W         = 17,
   parameter int REPEAT_DELAY  = DEB_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEB_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_in,
   output logic clean_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic repeat_pulse
);

   logic             r_s1;
   logic             r_s2;
   deb_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_clean;
   logic             r_rise;
   logic             r_fall;
   logic             w_diff;
   logic             w_done;

   assign w_diff = r_s2 ^ r_clean;
   assign w_done = w_diff && (r_cnt == CNT_W'(STABLE_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= raw_in;
         r_s2 <= r_s1;
      end
   end

   // Any return to the clean level while counting discards the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_STABLE;
         r_cnt   <= '0;
         r_clean <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         unique case (r_state)
            ST_STABLE: begin
               if (w_done) begin
                  r_clean <= r_s2;
                  r_rise  <= r_s2;
                  r_fall  <= !r_s2;
               end else if (w_diff) begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= ST_COUNTING;
               end
            end
            ST_COUNTING: begin
               if (!w_diff) begin
                  r_cnt   <= '0;
                  r_state <= ST_STABLE;
               end else if (w_done) begin
                  r_clean <= r_s2;
                  r_rise  <= r_s2;
                  r_fall  <= !r_s2;
                  r_cnt   <= '0;
                  r_state <= ST_STABLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= ST_STABLE;
            end
         endcase
      end
   end

   assign clean_out  = r_clean;
   assign rise_pulse = r_rise;
   assign fall_pulse = r_fall;

`ifdef DEBOUNCE_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = (clog2(RMAX) < 1) ? 1 : clog2(RMAX);

   logic [RW-1:0] r_rcnt;
   logic          r_first;
   logic          r_rep;

   // While high, w_done can only mean a falling update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rcnt  <= '0;
         r_first <= 1'b1;
         r_rep   <= 1'b0;
      end else if (!r_clean || w_done) begin
         r_rcnt  <= '0;
         r_first <= 1'b1;
         r_rep   <= 1'b0;
      end else begin
         r_rep <= 1'b0;
         if (r_first ? (r_rcnt == RW'(REPEAT_DELAY - 1))
                     : (r_rcnt == RW'(REPEAT_PERIOD - 1))) begin
            r_rep   <= 1'b1;
            r_rcnt  <= '0;
            r_first <= 1'b0;
         end else begin
            r_rcnt <= r_rcnt + 1'b1;
         end
      end
   end

   assign repeat_pulse = r_rep;
`else
   localparam logic REP_TIE = 1'b0 & (REPEAT_DELAY > 0) &
                              (REPEAT_PERIOD > 0);

   assign repeat_pulse = REP_TIE;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels for buttons and switches.
// Build option: DEBOUNCE_REPEAT_EN enables per-channel auto-repeat.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int CHANNELS      = 13,
   parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
   parameter int CNT_W         = 17,
   parameter int REPEAT_DELAY  = DEB_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEB_REPEAT_PERIOD
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] clean_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic [CHANNELS-1:0] repeat_pulse
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      debounce_chan #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .raw_in       (raw_in[g]),
         .clean_out    (clean_out[g]),
         .rise_pulse   (rise_pulse[g]),
         .fall_pulse   (fall_pulse[g]),
         .repeat_pulse (repeat_pulse[g])
      );
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (STABLE_CYCLES=8, repeat 20/5).
module tb_debounce_bank;

   localparam int CH = 13;

   logic          clk;
   logic          rst_n;
   logic [CH-1:0] raw;
   logic [CH-1:0] clean;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic [CH-1:0] rep;

   int n_checks = 0;
   int n_fail   = 0;

   debounce_bank #(
      .CHANNELS      (CH),
      .STABLE_CYCLES (8),
      .CNT_W         (4),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw_in       (raw),
      .clean_out    (clean),
      .rise_pulse   (rise),
      .fall_pulse   (fall),
      .repeat_pulse (rep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic [CH-1:0] v);
      rst_n = 1'b0;
      raw   = v;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [CH-1:0] ec;
      logic [CH-1:0] er;
      rst_n = 1'b0;
      raw   = '1;
      #1;
      n_checks++;
      if (clean !== '0 || rise !== '0 || fall !== '0 || rep !== '0) begin
         n_fail++;
         $display("FAIL reset_state clean=%h rise=%h fall=%h rep=%h want 0",
                  clean, rise, fall, rep);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         ec = (k >= 10) ? '1 : '0;
         er = (k == 10) ? '1 : '0;
         n_checks++;
         if (clean !== ec || rise !== er || fall !== '0) begin
            n_fail++;
            $display("FAIL reset_release k=%0d clean=%h rise=%h fall=%h want %h %h 0",
                     k, clean, rise, fall, ec, er);
         end
      end
   endtask

   task automatic test_rise_fall();
      apply_reset('0);
      raw[0] = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         n_checks++;
         if (clean[0] !== (k >= 10) || rise[0] !== (k == 10) ||
             fall !== '0 || clean[CH-1:1] !== '0) begin
            n_fail++;
            $display("FAIL ch0_rise k=%0d clean=%h rise=%h fall=%h",
                     k, clean, rise, fall);
         end
      end
      raw[0] = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         tick();
         n_checks++;
         if (clean[0] !== (k < 10) || fall[0] !== (k == 10) || rise !== '0) begin
            n_fail++;
            $display("FAIL ch0_fall k=%0d clean=%h rise=%h fall=%h",
                     k, clean, rise, fall);
         end
      end
   endtask

   task automatic test_glitch();
      logic [19:0] pat;
      apply_reset('0);
      pat = 20'b0000_0111_1111_0111_1111;
      for (int k = 0; k < 20; k++) begin
         raw[1] = pat[k];
         tick();
         n_checks++;
         if (clean !== '0 || rise !== '0 || fall !== '0) begin
            n_fail++;
            $display("FAIL ch1_glitch k=%0d clean=%h rise=%h fall=%h want 0",
                     k, clean, rise, fall);
         end
      end
   endtask

   task automatic test_chatter_indep();
      apply_reset('0);
      raw[3] = 1'b1;
      raw[2] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         raw[2] = ~raw[2];
         n_checks++;
         if (clean[3] !== (k >= 10) || rise[3] !== (k == 10) ||
             clean[2] !== 1'b0 || rise[2] !== 1'b0 || fall[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL ch3_vs_ch2 k=%0d clean=%h rise=%h fall=%h",
                     k, clean, rise, fall);
         end
      end
   endtask

   task automatic test_reset_midcount();
      logic [CH-1:0] ec;
      logic [CH-1:0] er;
      apply_reset(13'h1FEF);
      repeat (10) tick();
      n_checks++;
      if (clean !== 13'h1FEF) begin
         n_fail++;
         $display("FAIL ch4_setup clean=%h want 1fef", clean);
      end
      raw[4] = 1'b1;
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (clean !== '0 || rise !== '0 || fall !== '0) begin
         n_fail++;
         $display("FAIL ch4_async_clear clean=%h rise=%h fall=%h want 0",
                  clean, rise, fall);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         ec = (k >= 10) ? '1 : '0;
         er = (k == 10) ? '1 : '0;
         n_checks++;
         if (clean !== ec || rise !== er || fall !== '0) begin
            n_fail++;
            $display("FAIL ch4_after_reset k=%0d clean=%h rise=%h want %h %h",
                     k, clean, rise, ec, er);
         end
      end
   endtask

   task automatic test_repeat();
      logic er;
      apply_reset('0);
      raw[5] = 1'b1;
      for (int e = 1; e <= 42; e++) begin
         tick();
`ifdef DEBOUNCE_REPEAT_EN
         er = (e >= 30) && ((e - 30) % 5 == 0);
`else
         er = 1'b0;
`endif
         n_checks++;
         if (rep[5] !== er || rep[CH-1:6] !== '0 || rep[4:0] !== '0 ||
             clean[5] !== (e >= 10)) begin
            n_fail++;
            $display("FAIL ch5_repeat e=%0d rep=%h clean=%h want rep5=%b",
                     e, rep, clean, er);
         end
      end
      raw[5] = 1'b0;
      for (int e = 43; e <= 57; e++) begin
         tick();
`ifdef DEBOUNCE_REPEAT_EN
         er = (e == 45) || (e == 50);
`else
         er = 1'b0;
`endif
         n_checks++;
         if (rep[5] !== er || fall[5] !== (e == 52) ||
             clean[5] !== (e < 52)) begin
            n_fail++;
            $display("FAIL ch5_release e=%0d rep=%h fall=%h clean=%h want rep5=%b",
                     e, rep, fall, clean, er);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      raw   = '0;
      test_reset();
      test_rise_fall();
      test_glitch();
      test_chatter_indep();
      test_reset_midcount();
      test_repeat();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
